// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter: two-requester round-robin writeback arbiter for a
// single register-file write port, with a saturating stall counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              last_grant,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              w_nz0;
    logic              w_nz1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_stall;

    logic              reg_write_q,  reg_write_d;
    logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    // Writes to x0 are acknowledged but never reach the write port.
    always_comb begin
        w_nz0      = req0_valid && (req0_rd != '0);
        w_nz1      = req1_valid && (req1_rd != '0);
        w_gnt0     = w_nz0 && (!w_nz1 || last_grant_q);
        w_gnt1     = w_nz1 && (!w_nz0 || !last_grant_q);
        req0_ready = rst_n && req0_valid && (!w_nz0 || w_gnt0);
        req1_ready = rst_n && req1_valid && (!w_nz1 || w_gnt1);
        w_stall    = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);
    end

    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        last_grant_d = last_grant_q;
        stall_cnt_d  = stall_cnt_q;
        if (w_gnt0) begin
            reg_write_d  = 1'b1;
            write_reg_d  = req0_rd;
            write_data_d = req0_data;
            last_grant_d = 1'b0;
        end else if (w_gnt1) begin
            reg_write_d  = 1'b1;
            write_reg_d  = req1_rd;
            write_data_d = req1_data;
            last_grant_d = 1'b1;
        end
        if (w_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            last_grant_q <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            last_grant_q <= last_grant_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign last_grant = last_grant_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter: directed checks of the writeback arbiter, with a
// second narrow-counter instance for stall-counter saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              last_grant;
    logic [15:0]       stall_cnt;

    logic              s_req0_ready;
    logic              s_req1_ready;
    logic              s_reg_write;
    logic [ADDR_W-1:0] s_write_reg;
    logic [DATA_W-1:0] s_write_data;
    logic              s_last_grant;
    logic [3:0]        s_stall_cnt;

    int n_checks;
    int n_errors;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .last_grant(last_grant), .stall_cnt(stall_cnt)
    );

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(s_req1_ready),
        .reg_write(s_reg_write), .write_reg(s_write_reg), .write_data(s_write_data),
        .last_grant(s_last_grant), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        tick();
        idle_inputs();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        idle_inputs();

        // Reset values; ready stays low even with a valid request.
        #1 rst_n = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h1234;
        tick();
        check_val("rst_reg_write",  reg_write,  0);
        check_val("rst_write_reg",  write_reg,  0);
        check_val("rst_write_data", write_data, 0);
        check_val("rst_last_grant", last_grant, 1);
        check_val("rst_stall_cnt",  stall_cnt,  0);
        check_val("rst_ready0",     req0_ready, 0);
        idle_inputs();
        rst_n = 1'b1;

        // Single write from requester 0.
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hDEADBEEF;
        #1 check_val("single_ready0", req0_ready, 1);
        tick();
        idle_inputs();
        check_val("single_reg_write",  reg_write,  1);
        check_val("single_write_reg",  write_reg,  3);
        check_val("single_write_data", write_data, 32'hDEADBEEF);
        check_val("single_last_grant", last_grant, 0);
        tick();
        check_val("idle_reg_write", reg_write, 0);
        check_val("idle_hold_reg",  write_reg, 3);
        check_val("idle_hold_data", write_data, 32'hDEADBEEF);

        // Tie after reset alternates 0,1,0,1 with one stall per cycle.
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'hB1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val("tie_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
            check_val("tie_ready1", req1_ready, (k % 2 == 0) ? 0 : 1);
            tick();
            check_val("tie_write_reg", write_reg, (k % 2 == 0) ? 5 : 6);
            check_val("tie_last_grant", last_grant, (k % 2 == 0) ? 0 : 1);
        end
        check_val("tie_stall_cnt", stall_cnt, 4);
        idle_inputs();

        // x0 write from requester 1 is acknowledged and dropped.
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hFF;
        #1;
        check_val("x0_ready0", req0_ready, 1);
        check_val("x0_ready1", req1_ready, 1);
        tick();
        check_val("x0_write_reg",  write_reg,  7);
        check_val("x0_write_data", write_data, 32'h77);
        check_val("x0_last_grant", last_grant, 0);
        req0_valid = 1'b0;
        tick();
        check_val("x0_only_no_write", reg_write, 0);
        check_val("x0_only_lg_hold",  last_grant, 0);
        check_val("x0_stall_hold",    stall_cnt, 4);
        idle_inputs();

        // Same rd on both, last_grant=0 -> requester 1 first, then requester 0.
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd9; req1_data = 32'h22;
        #1 check_val("same_ready1_first", req1_ready, 1);
        tick();
        check_val("same_first_data", write_data, 32'h22);
        req1_valid = 1'b0;
        #1 check_val("same_ready0_second", req0_ready, 1);
        tick();
        check_val("same_second_we",   reg_write,  1);
        check_val("same_second_data", write_data, 32'h11);
        check_val("same_second_lg",   last_grant, 0);
        idle_inputs();

        // Saturation: one requester blocked every cycle for 20 cycles.
        do_reset();
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h1;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h2;
        for (int k = 0; k < 10; k++) tick();
        check_val("sat_cnt4_mid",  s_stall_cnt, 10);
        for (int k = 0; k < 10; k++) tick();
        check_val("sat_cnt4_stop", s_stall_cnt, 15);
        check_val("sat_cnt16",     stall_cnt,   20);
        idle_inputs();
        tick();

        // Reset asserted in the cycle after a grant.
        req0_valid = 1'b1; req0_rd = 5'd12; req0_data = 32'hCAFE;
        tick();
        check_val("rmw_we_before", reg_write, 1);
        rst_n = 1'b0;
        #1;
        check_val("rmw_we_now",     reg_write,  0);
        check_val("rmw_write_reg",  write_reg,  0);
        check_val("rmw_write_data", write_data, 0);
        check_val("rmw_last_grant", last_grant, 1);
        check_val("rmw_stall_cnt",  stall_cnt,  0);
        check_val("rmw_ready0",     req0_ready, 0);
        tick();
        tick();
        check_val("rmw_hold_we",  reg_write, 0);
        check_val("rmw_hold_reg", write_reg, 0);
        // First grant lands on the first edge after release.
        rst_n = 1'b1;
        tick();
        check_val("rel_first_we",  reg_write, 1);
        check_val("rel_first_reg", write_reg, 12);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of the writeback data.
REQ-002 Parameter ADDR_W, default 5, width of the register index (32 registers).
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 The port list SHALL be exactly REQ-005 to REQ-019; there is one clock, and reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req0_valid  in  1  requester 0 (ALU writeback) holds a write.
REQ-008 req0_rd  in  ADDR_W  requester 0 destination register.
REQ-009 req0_data  in  DATA_W  requester 0 write data.
REQ-010 req0_ready  out  1  requester 0 write accepted this cycle.
REQ-011 req1_valid  in  1  requester 1 (load/MUL writeback) holds a write.
REQ-012 req1_rd  in  ADDR_W  requester 1 destination register.
REQ-013 req1_data  in  DATA_W  requester 1 write data.
REQ-014 req1_ready  out  1  requester 1 write accepted this cycle.
REQ-015 reg_write  out  1  register-file write enable (registered).
REQ-016 write_reg  out  ADDR_W  register-file write index (registered).
REQ-017 write_data  out  DATA_W  register-file write data (registered).
REQ-018 last_grant  out  1  index of the requester most recently granted a nonzero-rd write.
REQ-019 stall_cnt  out  CNT_W  saturating count of cycles in which some valid request was not accepted.

Function
REQ-020 A transfer on requester n SHALL occur in any cycle where reqn_valid and reqn_ready are both 1 at the rising edge.
REQ-021 A requester SHALL hold valid, rd and data stable until accepted; the block's behaviour is undefined if it does not.
REQ-022 reqn_ready SHALL be combinational from the valid inputs, the rd inputs and last_grant, and SHALL NOT depend on reqn_data.
REQ-023 A request with rd==0 SHALL be given ready=1 in the same cycle it is valid, SHALL NOT consume the write port and SHALL NOT change last_grant.
REQ-024 If exactly one requester is valid with a nonzero rd, that requester SHALL get ready=1.
REQ-025 If both requesters are valid with nonzero rd, ready SHALL go to the requester not equal to last_grant, and the other requester SHALL get ready=0.
REQ-026 When both requesters target the same nonzero rd, arbitration SHALL follow REQ-025, giving serialized writes in grant order with no merging.
REQ-027 On a nonzero-rd grant to requester n, the block SHALL set, at the next edge: reg_write=1, write_reg=reqn_rd, write_data=reqn_data and last_grant=n; latency from acceptance to reg_write is exactly 1 cycle.
REQ-028 In any cycle with no nonzero-rd grant, reg_write SHALL be 0 at the next edge, while write_reg and write_data hold their previous values.
REQ-029 reg_write SHALL never be 1 with write_reg==0.
REQ-030 Throughput SHALL be one nonzero-rd write per cycle, sustained back-to-back.
REQ-031 A requester left waiting by REQ-025 SHALL be granted within 1 cycle while it stays valid (round-robin, no starvation).
REQ-032 stall_cnt SHALL increment by 1 in each cycle where (req0_valid and not req0_ready) or (req1_valid and not req1_ready).
REQ-033 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.

Reset
REQ-034 While rst_n=0, asynchronously: reg_write=0, write_reg=0, write_data=0, last_grant=1 (so requester 0 wins the first tie), stall_cnt=0.
REQ-035 While rst_n=0, req0_ready=0 and req1_ready=0.
REQ-036 Reset asserted mid-operation SHALL drop any pending write, and reg_write SHALL be 0 immediately.
REQ-037 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 Single: req0 valid rd=3 data=0xDEADBEEF -> req0_ready=1 the same cycle; next cycle reg_write=1, write_reg=3, write_data=0xDEADBEEF, last_grant=0.
REQ-039 Tie: both valid for 4 cycles (rd0=5, rd1=6, each reasserted after acceptance) -> grants 0,1,0,1 after reset; stall_cnt=4.
REQ-040 x0 drop: req1 valid rd=0 with req0 valid rd=7 -> both ready=1 the same cycle; only rd=7 is written; last_grant=0.
REQ-041 Same rd: both valid rd=9, data 0x11 (req0) and 0x22 (req1), last_grant=0 -> 0x22 is written first, then 0x11 on the next cycle.
REQ-042 Saturation: CNT_W=4, one requester blocked for 20 cycles -> stall_cnt stops at 15.
REQ-043 Reset mid-write: assert rst_n=0 in the cycle after a grant -> reg_write=0 immediately; all outputs hold reset values until release.
